pixel_feeder: RTL and testbench
===============================

Name: pixel_feeder

Overview:
- Upstream stage of the MNIST accelerator core. Accepts raw 8-bit grayscale pixels over a valid/ready stream and buffers them in a small FIFO.
- Converts each pixel to the core's DATA_WIDTH fixed-point format and issues exactly FRAME_LEN pixels per image on the core's serial input.
- After each frame it holds off the next frame until the core returns a prediction, then latches that prediction.
- Lets an external host stream images back-to-back without tracking core latency.

Parameters:
- DATA_WIDTH, 24, width of core pixel word (two's complement fixed point).
- FRAC_BITS, 16, fractional bits of core word; must be >= 8 and FRAC_BITS+1 <= DATA_WIDTH.
- FRAME_LEN, 784, pixels per image.
- FIFO_DEPTH, 16, input buffer entries; power of two, >= 2.
- TIMEOUT, 4096, max cycles waited for a core result; must be >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s_valid  in  1  host pixel valid
- s_pixel  in  8  host pixel, unsigned 0..255
- s_ready  out  1  feeder can accept a pixel
- pix_valid  out  1  to core i_valid
- pix_data  out  DATA_WIDTH  to core pixel
- core_valid  in  1  from core o_valid
- core_digit  in  4  from core digit
- res_valid  out  1  one-cycle pulse: new prediction latched
- res_digit  out  4  last latched prediction
- frame_count  out  16  completed frames, wraps at 65535->0
- timeout_err  out  1  sticky: a frame timed out

Behaviour:
- Reset (async assert; synchronous deassert is the integrator's job) clears:
  - FIFO pointers.
  - State to STREAM.
  - Pixel counter and wait counter.
  - All outputs to 0, except s_ready, which is 1 out of reset because the FIFO is empty.
- Reset mid-frame discards all buffered and partial-frame data.
- Input handshake:
  - Push when s_valid && s_ready.
  - s_ready = !full, combinational from registered pointers only.
  - No fall-through: a pixel pushed into an empty FIFO can pop no earlier than the next cycle.
  - When the FIFO is full, a pop in the same cycle does not raise s_ready that cycle.
- Conversion: pix_data = zero_extend(pixel) << (FRAC_BITS-8), so value = pixel/256. The result is always non-negative and the MSB is always 0.
- Output:
  - pix_valid and pix_data are registered.
  - A pop at cycle t gives pix_valid=1 at t+1 with that pixel.
  - pix_valid=0 on cycles with no pop. Gaps are allowed and the core tolerates them.
  - pix_data holds its last value when pix_valid=0.
- State STREAM:
  - Pop whenever the FIFO is not empty. Pixel counter increments per pop.
  - On the pop with counter == FRAME_LEN-1: counter goes to 0 and the state goes to WAIT.
  - Exactly FRAME_LEN pops per frame, never more.
- State WAIT:
  - No pops. The FIFO keeps accepting pushes.
  - Wait counter increments each cycle.
  - On core_valid: res_digit <= core_digit, res_valid pulses 1 cycle, frame_count++, wait counter goes to 0, state goes to STREAM. Popping may resume that same cycle.
  - If the wait counter reaches TIMEOUT-1 without core_valid: timeout_err <= 1 (sticky until reset), res_valid stays 0, res_digit is unchanged, frame_count is unchanged, wait counter goes to 0, state goes to STREAM.
- core_valid received in STREAM is ignored: no latch, no count.
- core_valid and the timeout limit in the same cycle: core_valid wins and timeout_err is not set.
- frame_count wraps modulo 2^16 with no flag.
- Simultaneous push and pop when neither full nor empty: occupancy is unchanged.

Test Plan:
- Reset, then push 784 pixels of value 255 with s_valid held high -> 784 pix_valid pulses, each pix_data = 0x00FF00 (DATA_WIDTH=24, FRAC_BITS=16); the 785th pushed pixel is not popped until core_valid.
- Push pixels 0,1,128 into an empty FIFO -> pix_data 0x000000, 0x000100, 0x008000 in order; first pix_valid exactly 2 cycles after the first push.
- After frame 1, hold s_valid high with core_valid low -> s_ready drops after 16 more pushes. Then core_valid=1 with core_digit=7 -> res_valid pulses once, res_digit=7, frame_count=1, popping resumes, s_ready returns high.
- No core_valid for 4096 cycles after a frame -> timeout_err=1, frame_count=0, next frame streams. A later core_valid with digit 3 -> res_digit=3, frame_count=1, timeout_err still 1.
- Assert rst after 300 pixels of a frame with 10 buffered -> all outputs 0, s_ready=1. The next 784 pushes form a complete frame, and the pixel count restarts at 0.
- core_valid pulsed during STREAM -> res_valid stays 0, res_digit and frame_count unchanged.

Source files
------------

// File: rtl/pixel_feeder.sv
// Upstream feeder for the MNIST core: buffers host pixels, converts them to fixed point and
// paces exactly one frame at a time into the core, latching each prediction it returns.
module pixel_feeder #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned FRAC_BITS  = 16,
  parameter int unsigned FRAME_LEN  = 784,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [7:0]            s_pixel,
  output logic                  s_ready,
  output logic                  pix_valid,
  output logic [DATA_WIDTH-1:0] pix_data,
  input  logic                  core_valid,
  input  logic [3:0]            core_digit,
  output logic                  res_valid,
  output logic [3:0]            res_digit,
  output logic [15:0]           frame_count,
  output logic                  timeout_err
);

  localparam int unsigned AddrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned PixCntW = $clog2(FRAME_LEN + 1);
  localparam int unsigned WaitW   = $clog2(TIMEOUT);
  localparam int unsigned Shift   = FRAC_BITS - 8;

  typedef enum logic {StStream, StWait} state_e;

  state_e               state_q, state_d;
  logic [7:0]           mem [FIFO_DEPTH];
  logic [AddrW:0]       wptr_q, rptr_q;
  logic [PixCntW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [WaitW-1:0]     wait_cnt_q, wait_cnt_d;
  logic                 pix_valid_q;
  logic [DATA_WIDTH-1:0] pix_data_q, pix_conv;
  logic                 res_valid_q;
  logic [3:0]           res_digit_q;
  logic [15:0]          frame_count_q;
  logic                 timeout_err_q;
  logic                 full, empty, push, pop, res_latch, timeout_hit;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                    (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign s_ready  = ~full;
  assign push     = s_valid & ~full;
  assign pix_conv = DATA_WIDTH'(mem[rptr_q[AddrW-1:0]]) << Shift;

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    pop         = 1'b0;
    res_latch   = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      StStream: begin
        if (!empty) begin
          pop = 1'b1;
          if (pix_cnt_q == PixCntW'(FRAME_LEN - 1)) begin
            pix_cnt_d = '0;
            state_d   = StWait;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end
      StWait: begin
        // A result arriving on the limit cycle still counts as a result.
        if (core_valid) begin
          res_latch  = 1'b1;
          wait_cnt_d = '0;
          state_d    = StStream;
        end else if (wait_cnt_q == WaitW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          wait_cnt_d  = '0;
          state_d     = StStream;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = StStream;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AddrW-1:0]] <= s_pixel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StStream;
      wptr_q        <= '0;
      rptr_q        <= '0;
      pix_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      res_valid_q   <= 1'b0;
      res_digit_q   <= '0;
      frame_count_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      pix_valid_q <= pop;
      res_valid_q <= res_latch;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) begin
        rptr_q     <= rptr_q + 1'b1;
        pix_data_q <= pix_conv;
      end
      if (res_latch) begin
        res_digit_q   <= core_digit;
        frame_count_q <= frame_count_q + 16'd1;
      end
      if (timeout_hit) timeout_err_q <= 1'b1;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign res_valid   = res_valid_q;
  assign res_digit   = res_digit_q;
  assign frame_count = frame_count_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pixel_feeder.sv
// Directed bench for pixel_feeder: conversion table, latency, frame pacing, backpressure,
// result latching, timeout and mid-frame reset.
`timescale 1ns/1ps
module tb_pixel_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [7:0]  s_pixel;
  logic        s_ready;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        core_valid;
  logic [3:0]  core_digit;
  logic        res_valid;
  logic [3:0]  res_digit;
  logic [15:0] frame_count;
  logic        timeout_err;

  pixel_feeder #(
    .DATA_WIDTH(24),
    .FRAC_BITS (16),
    .FRAME_LEN (784),
    .FIFO_DEPTH(16),
    .TIMEOUT   (4096)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_pixel    (s_pixel),
    .s_ready    (s_ready),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .core_valid (core_valid),
    .core_digit (core_digit),
    .res_valid  (res_valid),
    .res_digit  (res_digit),
    .frame_count(frame_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pixel;
    logic [23:0] data;
  } vec_t;

  vec_t        tbl [6];
  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc = 0, push_cnt = 0, pix_cnt = 0, res_cnt = 0, last_pix_cyc = 0;
  logic [23:0] pix_q [$];

  // Observer only: counts handshakes and records converted pixels.
  always @(negedge clk) begin
    cyc++;
    if (s_valid && s_ready) push_cnt++;
    if (pix_valid) begin
      pix_cnt++;
      pix_q.push_back(pix_data);
      last_pix_cyc = cyc;
    end
    if (res_valid) res_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic stream_until(input int target, input int max_cyc);
    int n = 0;
    s_pixel = 8'd255;
    s_valid = 1'b1;
    while (push_cnt < target && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    s_valid = 1'b0;
    check("stream_pushes", push_cnt, target);
  endtask

  task automatic wait_pix(input int target, input int max_cyc);
    int n = 0;
    while (pix_cnt < target && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic pulse_core(input logic [3:0] d);
    core_valid = 1'b1;
    core_digit = d;
    @(posedge clk); #1;
    core_valid = 1'b0;
    core_digit = 4'd0;
  endtask

  function automatic int bad_frames_from(input int base);
    int bad = 0;
    for (int i = base; i < pix_q.size(); i++) if (pix_q[i] !== 24'h00FF00) bad++;
    return bad;
  endfunction

  initial begin
    int qb, pb, ub, rb, t;
    tbl[0] = '{8'd0,   24'h000000};
    tbl[1] = '{8'd1,   24'h000100};
    tbl[2] = '{8'd128, 24'h008000};
    tbl[3] = '{8'd255, 24'h00FF00};
    tbl[4] = '{8'd7,   24'h000700};
    tbl[5] = '{8'd64,  24'h004000};

    rst = 1'b1; s_valid = 1'b0; s_pixel = 8'd0; core_valid = 1'b0; core_digit = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_digit", res_digit, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Conversion table, pushed back-to-back into an empty FIFO.
    qb = pix_q.size();
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_pixel = tbl[i].pixel;
      if (i == 1) check("latency_cycle1", pix_valid, 0);
      if (i == 2) check("latency_cycle2", pix_valid, 1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("tbl_count", pix_q.size() - qb, 6);
    for (int i = 0; i < 6; i++) check($sformatf("tbl_data%0d", i), pix_q[qb + i], tbl[i].data);
    check("hold_valid", pix_valid, 0);
    check("hold_data", pix_data, 24'h004000);

    // Mid-frame asynchronous reset while pixels are flowing.
    stream_until(push_cnt + 300, 1000);
    check("pre_rst_valid", pix_valid, 1);
    rst = 1'b1;
    #1;
    check("midrst_pix_valid", pix_valid, 0);
    check("midrst_pix_data", pix_data, 0);
    check("midrst_s_ready", s_ready, 1);
    check("midrst_frame_count", frame_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pb = pix_cnt; ub = push_cnt; qb = pix_q.size(); rb = res_cnt;

    // Frame 1 plus 16 extra pushes that must stay buffered until a result.
    stream_until(ub + 800, 3000);
    repeat (10) @(posedge clk);
    #1;
    check("fill_s_ready", s_ready, 0);
    check("frame1_pops", pix_cnt - pb, 784);
    check("frame1_data", bad_frames_from(qb), 0);
    check("wait_res_cnt", res_cnt - rb, 0);
    check("wait_frame_count", frame_count, 0);
    check("wait_timeout", timeout_err, 0);

    pulse_core(4'd7);
    repeat (3) @(posedge clk);
    #1;
    check("res7_pulses", res_cnt - rb, 1);
    check("res7_digit", res_digit, 7);
    check("res7_frame_count", frame_count, 1);
    check("res7_s_ready", s_ready, 1);
    check("res7_resumed", pix_cnt - pb > 784, 1);

    // A result during streaming must be ignored.
    pulse_core(4'd9);
    repeat (3) @(posedge clk);
    #1;
    check("stream_cv_pulses", res_cnt - rb, 1);
    check("stream_cv_digit", res_digit, 7);
    check("stream_cv_frame_count", frame_count, 1);

    // Finish frame 2 and let the core time out.
    stream_until(ub + 1568, 3000);
    wait_pix(pb + 1568, 100);
    check("frame2_pops", pix_cnt - pb, 1568);
    t = 0;
    while (!timeout_err && t < 5000) begin
      @(negedge clk); #1;
      t++;
    end
    check("timeout_seen", timeout_err, 1);
    check("timeout_delay", cyc - last_pix_cyc, 4096);
    check("timeout_frame_count", frame_count, 1);
    check("timeout_res_digit", res_digit, 7);
    check("timeout_res_cnt", res_cnt - rb, 1);

    // Frame 3 streams after the timeout; then a late result.
    @(posedge clk); #1;
    stream_until(ub + 2352, 3000);
    wait_pix(pb + 2352, 100);
    repeat (5) @(posedge clk);
    #1;
    check("frame3_pops", pix_cnt - pb, 2352);
    check("all_frame_data", bad_frames_from(qb), 0);
    pulse_core(4'd3);
    repeat (2) @(posedge clk);
    #1;
    check("res3_digit", res_digit, 3);
    check("res3_frame_count", frame_count, 2);
    check("res3_timeout_sticky", timeout_err, 1);
    check("res3_pulses", res_cnt - rb, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
